// File: rtl/div_iter_if.sv
// Handshake and operand/result bundle between the divide-stall controller
// (master) and the iterative divider (slave).
interface div_iter_if #(
    parameter int WIDTH = 32
) ();
    logic                 div_start;
    logic                 div_signed;
    logic                 annul;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic [2*WIDTH-1:0]   div_result;
    logic                 div_ready;

    modport master (
        output div_start, div_signed, annul, opdata1, opdata2,
        input  div_result, div_ready
    );

    modport slave (
        input  div_start, div_signed, annul, opdata1, opdata2,
        output div_result, div_ready
    );
endinterface

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} for the HI/LO write with a one-cycle
// div_ready pulse. Operands are captured on acceptance, so the EX stage
// may change them while the division runs.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    div_iter_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, DONE} state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     rem_q;      // partial remainder
    logic [WIDTH-1:0]     quo_q;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]     dvs_q;      // divisor magnitude
    logic                 neg_quo_q;  // negate quotient at the end
    logic                 neg_rem_q;  // negate remainder at the end
    logic [2*WIDTH-1:0]   result_q;
    logic                 ready_q;

    logic [WIDTH:0]       shift_d;
    logic [WIDTH:0]       trial_d;
    logic [WIDTH-1:0]     rem_d;
    logic [WIDTH-1:0]     quo_d;
    logic [WIDTH-1:0]     quo_fix_d;
    logic [WIDTH-1:0]     rem_fix_d;

    // Magnitude of an operand; only negative values in signed mode change.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    // One restoring step: shift {rem, q} left, try subtracting the divisor,
    // keep the difference only when it did not go negative.
    assign shift_d   = {rem_q, quo_q[WIDTH-1]};
    assign trial_d   = shift_d - {1'b0, dvs_q};
    assign rem_d     = trial_d[WIDTH] ? shift_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
    assign quo_d     = {quo_q[WIDTH-2:0], ~trial_d[WIDTH]};

    // Sign fix-up: quotient negative iff signs differ, remainder follows dividend.
    assign quo_fix_d = neg_quo_q ? (~quo_d + 1'b1) : quo_d;
    assign rem_fix_d = neg_rem_q ? (~rem_d + 1'b1) : rem_d;

    assign bus.div_result = result_q;
    assign bus.div_ready  = ready_q;

    // Control FSM and datapath; annul overrides everything except reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state registers are assigned with <= so every register
            // samples pre-edge values, independent of statement order.
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else if (bus.annul) begin
            // Abort: drop back to IDLE, leave div_result untouched, no pulse.
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.div_start) begin
                        neg_quo_q <= bus.div_signed & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                        neg_rem_q <= bus.div_signed & bus.opdata1[WIDTH-1];
                        rem_q     <= '0;
                        quo_q     <= mag(bus.opdata1, bus.div_signed);
                        dvs_q     <= mag(bus.opdata2, bus.div_signed);
                        cnt_q     <= '0;
                        state_q   <= (bus.opdata2 == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    result_q <= '0;
                    ready_q  <= 1'b1;
                    state_q  <= DONE;
                end
                ON: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_q <= {rem_fix_d, quo_fix_d};
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    // A still-high div_start is deliberately not re-accepted here.
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases followed by
// randomized operations compared against an arithmetic reference model.
module tb_div_iter;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_iter_if #(.WIDTH(WIDTH)) bus ();

    div_iter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, truncating toward zero, with the
    // quotient/remainder wrapped to WIDTH bits. Divide by zero gives 0.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint x;
        longint y;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            x = $signed(a);
            y = $signed(b);
        end else begin
            x = a;
            y = b;
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run for a number of cycles and require that no ready pulse appears.
    task automatic watch_quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        repeat (cycles) begin
            tick();
            if (bus.div_ready === 1'b1) pulses++;
        end
        check(tag, 64'(pulses), 64'd0);
    endtask

    // Issue one division, scramble operands once accepted, measure latency
    // (accepting edge counted as 1), check result, pulse width and hold.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input bit hold_done);
        int n;
        bit seen;
        bus.div_start  = 1'b1;
        bus.div_signed = s;
        bus.opdata1    = a;
        bus.opdata2    = b;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (n == 1) begin
                bus.opdata1    = $urandom;
                bus.opdata2    = $urandom;
                bus.div_signed = 1'($urandom_range(0, 1));
            end
            seen = (bus.div_ready === 1'b1);
        end
        check({tag, "/latency"}, 64'(n), (b == 32'd0) ? 64'd2 : 64'(WIDTH + 1));
        check({tag, "/result"}, bus.div_result, exp);
        if (hold_done) begin
            // Keep start high through DONE with a zero divisor on the bus:
            // a wrongful re-accept would produce a divide-by-zero pulse.
            bus.opdata2 = 32'd0;
            tick();
            check({tag, "/ready_drop"}, 64'(bus.div_ready), 64'd0);
            bus.div_start = 1'b0;
            watch_quiet({tag, "/no_reaccept"}, 6);
        end else begin
            bus.div_start = 1'b0;
            tick();
            check({tag, "/ready_drop"}, 64'(bus.div_ready), 64'd0);
            check({tag, "/result_hold"}, bus.div_result, exp);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.annul      = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;

        // Reset state
        repeat (3) tick();
        check("reset/ready", 64'(bus.div_ready), 64'd0);
        check("reset/result", bus.div_result, 64'd0);
        rst = 1'b0;
        tick();

        // Directed arithmetic cases
        run_op("u_ffffffff_div_2", 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h00000001_7FFFFFFF, 1'b0);
        run_op("s_m7_div_2",       32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run_op("s_7_div_m2_hold",  32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, 1'b1);
        run_op("s_min_div_m1",     32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 1'b0);
        run_op("u_5_div_9",        32'h0000_0005, 32'h0000_0009, 1'b0, 64'h00000005_00000000, 1'b0);

        // Abort at iteration 10 of 100/7
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.opdata1    = 32'd100;
        bus.opdata2    = 32'd7;
        tick();
        repeat (10) tick();
        bus.annul     = 1'b1;
        bus.div_start = 1'b0;
        tick();
        check("annul/ready", 64'(bus.div_ready), 64'd0);
        check("annul/result_unchanged", bus.div_result, 64'h00000005_00000000);
        bus.annul = 1'b0;
        watch_quiet("annul/no_pulse", 40);
        check("annul/result_still", bus.div_result, 64'h00000005_00000000);

        // annul beats div_start in IDLE
        bus.div_start = 1'b1;
        bus.annul     = 1'b1;
        tick();
        bus.div_start = 1'b0;
        bus.annul     = 1'b0;
        watch_quiet("annul_idle/no_pulse", 40);

        run_op("u_100_div_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1'b0);

        // Divide by zero, then a normal operation
        run_op("div_by_zero", 32'h0000_1234, 32'd0, 1'b0, 64'd0, 1'b0);
        run_op("after_zero",  32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1'b0);

        // Reset in the middle of an operation
        bus.div_start = 1'b1;
        bus.opdata1   = 32'd1000;
        bus.opdata2   = 32'd3;
        tick();
        repeat (5) tick();
        rst           = 1'b1;
        bus.div_start = 1'b0;
        tick();
        check("rst_mid/ready", 64'(bus.div_ready), 64'd0);
        check("rst_mid/result", bus.div_result, 64'd0);
        rst = 1'b0;
        watch_quiet("rst_mid/no_pulse", 40);
        run_op("after_rst", 32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, 1'b0);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = (i % 5 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: rb = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            run_op($sformatf("rand%0d_%s_%h_%h", i, rs ? "s" : "u", ra, rb),
                   ra, rb, rs, ref_div(ra, rb, rs), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage.
- Receives div_start/div_signed from the divide-stall controller and returns div_ready plus a 64-bit {remainder, quotient} result for the HI/LO write.
- Serves DIV and DIVU.
- Holds its own operand copies, so EX operands may change once the operation is accepted.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
div_start  in  1  request; held high by the controller until div_ready is seen.
div_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with div_start.
annul  in  1  pipeline flush; aborts any operation in progress.
opdata1  in  WIDTH  dividend.
opdata2  in  WIDTH  divisor.
div_result  out  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
div_ready  out  1  one-cycle completion pulse; div_result is valid in that cycle.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- On rst: state=IDLE, div_ready=0, div_result=0, counter=0, internal registers cleared.
- div_ready and div_result are registered outputs.
- States: IDLE, BYZERO, ON, DONE.

State transitions:
- IDLE:
  - If div_start=1 and annul=0: latch opdata1, opdata2 and div_signed.
  - Go to BYZERO if opdata2==0, else go to ON.
  - Otherwise stay in IDLE; div_ready=0.
- ON (setup on entry):
  - In signed mode, replace each negative operand with its two's-complement magnitude.
  - Load partial remainder=0, quotient shift reg=|dividend|, cnt=0.
- ON (each cycle, one step):
  - Shift {rem, q} left by 1.
  - trial = rem - |divisor| (WIDTH+1 bits).
  - If trial is non-negative: rem=trial, q[0]=1; else q[0]=0.
  - cnt++.
  - After the step with cnt==WIDTH-1, go to DONE.
- ON (sign fix-up, applied when loading div_result):
  - Signed mode only.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
- BYZERO: load div_result=0, then go to DONE.
- DONE:
  - div_ready=1 for exactly one cycle; div_result holds the final value.
  - Next state is IDLE unconditionally.
  - A div_start still high in this cycle is not re-accepted; the controller drops it combinationally on div_ready.
- Latency:
  - div_start accepted at cycle T (nonzero divisor): DONE/div_ready=1 at T+WIDTH+1, i.e. T+33.
  - Divide by zero: div_ready=1 at T+2.
- div_result persists after DONE until the next completion or rst. div_ready returns to 0.
- annul:
  - annul=1 in any state returns to IDLE next cycle with div_ready=0.
  - div_result is not updated, and no ready pulse is ever produced for the aborted operation.
  - annul has priority over div_start in IDLE.
- Operand hold: opdata1/opdata2/div_signed changes while in ON or BYZERO have no effect.
- div_start low while in ON: ignored; the operation completes. Only annul aborts.
- Boundary cases:
  - 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0 (wrap, no trap).
  - |dividend| < |divisor|: quotient 0, remainder = dividend.

Test Plan:
- Unsigned: start, div_signed=0, 0xFFFFFFFF/0x00000002 -> div_ready exactly 33 cycles after acceptance, div_result=0x00000001_7FFFFFFF, ready high for 1 cycle.
- Signed: 0xFFFFFFF9 (-7) / 0x00000002 -> div_result=0xFFFFFFFF_FFFFFFFD. Also 7/-2 -> 0x00000001_FFFFFFFD.
- Overflow/corner: signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000. Unsigned 5/9 -> 0x00000005_00000000.
- Divide by zero: 0x1234/0 with start -> div_ready at T+2, div_result=0. Next op is accepted normally.
- Abort: start 100/7, assert annul at iteration 10 -> IDLE next cycle, no ready pulse, div_result unchanged. A fresh 100/7 then yields 0x00000002_0000000E.
- Handshake/reset: start held through DONE -> no second acceptance in the DONE cycle. rst asserted mid-ON -> div_ready=0, div_result=0 next cycle, state IDLE.
